// File: rtl/event_fifo.sv
// event_fifo: first-word-fall-through event FIFO with drop counter and soft flush.
// Define EVENT_FIFO_IRQ_EN to enable the hysteresis fill-level interrupt (irq ties to 0 otherwise).
module event_fifo #(
    parameter int FIFO_AWIDTH = 4,
    parameter int RF_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   evt_valid,
    input  logic [RF_WIDTH-1:0]    evt_data,
    output logic                   evt_ready,
    input  logic                   fifo_rst_n,
    input  logic                   fifo_rd_en,
    output logic [RF_WIDTH-1:0]    fifo_rd_data,
    output logic [FIFO_AWIDTH-1:0] fifo_numel,
    input  logic [FIFO_AWIDTH-1:0] irq_assert_thresh,
    input  logic [FIFO_AWIDTH-1:0] irq_deassert_thresh,
    output logic                   irq,
    output logic [15:0]            drop_cnt
);
    localparam logic [FIFO_AWIDTH-1:0] CAP = '1;

    logic [RF_WIDTH-1:0]    mem [2**FIFO_AWIDTH];
    logic [FIFO_AWIDTH-1:0] wptr, rptr;
    logic                   wr, pop;

    // One slot is sacrificed so the pointer difference is the occupancy.
    assign fifo_numel   = wptr - rptr;
    assign evt_ready    = fifo_numel != CAP;
    assign wr           = evt_valid && evt_ready;
    assign pop          = fifo_rd_en && fifo_numel != '0;
    assign fifo_rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst || !fifo_rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            drop_cnt <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (evt_valid && !evt_ready && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fifo_rst_n && wr) mem[wptr] <= evt_data;
    end

`ifdef EVENT_FIFO_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst || !fifo_rst_n) irq <= 1'b0;
        else if (irq_assert_thresh != '0 && fifo_numel >= irq_assert_thresh) irq <= 1'b1;
        else if (fifo_numel <= irq_deassert_thresh) irq <= 1'b0;
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^{irq_assert_thresh, irq_deassert_thresh};
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_event_fifo.sv
// tb_event_fifo: directed and random stimulus against a queue-based reference of event_fifo.
module tb_event_fifo;
`ifdef EVENT_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    logic        clk = 0, rst = 1, evt_valid = 0, fifo_rst_n = 1, fifo_rd_en = 0;
    logic [31:0] evt_data = 0;
    logic [3:0]  irq_assert_thresh = 4'd10, irq_deassert_thresh = 4'd4;
    logic        evt_ready, irq;
    logic [31:0] fifo_rd_data;
    logic [3:0]  fifo_numel;
    logic [15:0] drop_cnt;
    int errors = 0, checks = 0;
    bit on = 0;

    logic [31:0] mq[$];
    int mdrop = 0;
    bit mirq = 0;

    event_fifo #(.FIFO_AWIDTH(4), .RF_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .fifo_rst_n(fifo_rst_n), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_numel(fifo_numel), .irq_assert_thresh(irq_assert_thresh),
        .irq_deassert_thresh(irq_deassert_thresh), .irq(irq), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: occupancy is the queue size, irq follows the hysteresis rule on the old size.
    always @(posedge clk) begin
        int n;
        if (rst || !fifo_rst_n) begin
            mq.delete();
            mdrop = 0;
            mirq = 0;
        end else begin
            n = mq.size();
            if (IRQ_ON) begin
                if (irq_assert_thresh != 0 && n >= int'(irq_assert_thresh)) mirq = 1;
                else if (n <= int'(irq_deassert_thresh)) mirq = 0;
            end
            if (evt_valid && n == 15 && mdrop < 65535) mdrop++;
            if (fifo_rd_en && n != 0) void'(mq.pop_front());
            if (evt_valid && n != 15) mq.push_back(evt_data);
        end
    end

    always @(negedge clk) begin
        if (on) begin
            chk("numel", 32'(fifo_numel), 32'(mq.size()));
            chk("ready", 32'(evt_ready), 32'(mq.size() != 15));
            chk("drop", 32'(drop_cnt), 32'(mdrop));
            chk("irq", 32'(irq), 32'(mirq));
            if (mq.size() != 0) chk("rd_data", fifo_rd_data, mq[0]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            evt_valid = 1;
            evt_data = base + 32'(i);
            cyc();
        end
        evt_valid = 0;
    endtask

    task automatic pop(input int n);
        fifo_rd_en = 1;
        repeat (n) cyc();
        fifo_rd_en = 0;
    endtask

    initial begin
        @(negedge clk);
        cyc();
        rst = 0;
        on = 1;
        chk("rst_numel", 32'(fifo_numel), 0);
        chk("rst_ready", 32'(evt_ready), 1);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_irq", 32'(irq), 0);

        push(15, 32'h100);
        chk("full_numel", 32'(fifo_numel), 15);
        chk("full_ready", 32'(evt_ready), 0);
        evt_valid = 1;
        evt_data = 32'hDEAD;
        cyc();
        evt_valid = 0;
        chk("drop_one", 32'(drop_cnt), 1);
        chk("full_head", fifo_rd_data, 32'h100);
        for (int i = 0; i < 15; i++) begin
            chk("drain_data", fifo_rd_data, 32'h100 + 32'(i));
            pop(1);
        end
        chk("empty_numel", 32'(fifo_numel), 0);
        pop(1);
        chk("empty_pop", 32'(fifo_numel), 0);

        push(10, 32'h400);
        chk("irq_lag", 32'(irq), 0);
        cyc();
        chk("irq_set", 32'(irq), 32'(IRQ_ON));
        pop(5);
        cyc();
        chk("irq_hold5", 32'(irq), 32'(IRQ_ON));
        pop(1);
        cyc();
        chk("irq_clr4", 32'(irq), 0);
        pop(4);

        push(7, 32'h200);
        evt_valid = 1;
        fifo_rd_en = 1;
        for (int i = 0; i < 20; i++) begin
            evt_data = 32'h300 + 32'(i);
            cyc();
            chk("wrap_numel", 32'(fifo_numel), 7);
        end
        evt_valid = 0;
        fifo_rd_en = 0;
        chk("wrap_head", fifo_rd_data, 32'h30D);

        fifo_rst_n = 0;
        cyc();
        fifo_rst_n = 1;
        push(15, 32'h500);
        evt_valid = 1;
        repeat (3) cyc();
        evt_valid = 0;
        pop(6);
        chk("pre_flush_numel", 32'(fifo_numel), 9);
        chk("pre_flush_drop", 32'(drop_cnt), 3);
        chk("pre_flush_irq", 32'(irq), 32'(IRQ_ON));
        fifo_rst_n = 0;
        cyc();
        fifo_rst_n = 1;
        chk("flush_numel", 32'(fifo_numel), 0);
        chk("flush_drop", 32'(drop_cnt), 0);
        chk("flush_irq", 32'(irq), 0);
        push(1, 32'hABC);
        chk("post_flush_data", fifo_rd_data, 32'hABC);
        chk("post_flush_numel", 32'(fifo_numel), 1);

        push(15, 32'h600);
        pop(4);
        evt_valid = 1;
        fifo_rd_en = 1;
        rst = 1;
        cyc();
        rst = 0;
        evt_valid = 0;
        fifo_rd_en = 0;
        chk("rst_mid_numel", 32'(fifo_numel), 0);
        chk("rst_mid_ready", 32'(evt_ready), 1);
        chk("rst_mid_drop", 32'(drop_cnt), 0);
        chk("rst_mid_irq", 32'(irq), 0);

        for (int i = 0; i < 4000; i++) begin
            bit fillp;
            fillp = ((i / 97) % 2) == 0;
            evt_valid = $urandom_range(0, 9) < (fillp ? 8 : 3);
            fifo_rd_en = $urandom_range(0, 9) < (fillp ? 3 : 8);
            evt_data = $urandom;
            fifo_rst_n = $urandom_range(0, 199) != 0;
            rst = $urandom_range(0, 499) == 0;
            if (i % 150 == 0) begin
                irq_assert_thresh = 4'($urandom_range(0, 15));
                irq_deassert_thresh = 4'($urandom_range(0, 15));
            end
            cyc();
        end
        rst = 0;
        fifo_rst_n = 1;
        evt_valid = 0;
        fifo_rd_en = 0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/event_fifo.md
EVENT_FIFO -- requirements
Module: event_fifo

Interface
- REQ-001 SHALL provide `clk  input  1`: single clock; all state updates on the rising edge.
- REQ-002 SHALL provide `rst  input  1`: reset, synchronous, active-high.
- REQ-003 SHALL provide `evt_valid  input  1`: upstream pixel-readout event valid.
- REQ-004 SHALL provide `evt_data  input  RF_WIDTH`: upstream event word.
- REQ-005 SHALL provide `evt_ready  output  1`: FIFO can accept an event.
- REQ-006 SHALL provide `fifo_rst_n  input  1`: regfile soft flush, active-low, sampled synchronously.
- REQ-007 SHALL provide `fifo_rd_en  input  1`: regfile pop strobe, one entry per high cycle.
- REQ-008 SHALL provide `fifo_rd_data  output  RF_WIDTH`: head entry, first-word-fall-through.
- REQ-009 SHALL provide `fifo_numel  output  FIFO_AWIDTH`: current occupancy, fed to the regfile.
- REQ-010 SHALL provide `irq_assert_thresh  input  FIFO_AWIDTH`: IRQ set level.
- REQ-011 SHALL provide `irq_deassert_thresh  input  FIFO_AWIDTH`: IRQ clear level.
- REQ-012 SHALL provide `irq  output  1`: fill-level interrupt.
- REQ-013 SHALL provide `drop_cnt  output  16`: count of dropped events.

Function
- REQ-014 SHALL store up to CAP = 2**FIFO_AWIDTH-1 entries in a circular buffer with FIFO_AWIDTH-bit wrapping read and write pointers; occupancy SHALL always fit `fifo_numel`.
- REQ-015 SHALL drive `evt_ready` = (`fifo_numel` != CAP); a write occurs when `evt_valid` && `evt_ready`.
- REQ-016 SHALL perform a pop when `fifo_rd_en` && `fifo_numel` != 0; `fifo_rd_en` on empty SHALL be ignored with no pointer change.
- REQ-017 SHALL present the head entry on `fifo_rd_data` combinationally from the read pointer; `fifo_rd_data` is don't-care when empty.
- REQ-018 SHALL update `fifo_numel` one cycle after a write or pop: +1 on a write only, -1 on a pop only, unchanged on a simultaneous write and pop.
- REQ-019 SHALL make a write into an empty FIFO visible on `fifo_rd_data` in the next cycle; a same-cycle pop on empty SHALL be ignored (REQ-016).
- REQ-020 SHALL block writes when full even if a pop occurs in the same cycle.
- REQ-021 SHALL increment `drop_cnt` each cycle with `evt_valid` && !`evt_ready`, saturating at 16'hFFFF.
- REQ-022 SHALL treat `fifo_rst_n`=0 as a flush: pointers, `fifo_numel`, `drop_cnt` and `irq` cleared next cycle; concurrent writes and pops are discarded.
- REQ-023 SHALL give priority rst > flush > write/pop.

Reset
- REQ-024 SHALL, on `rst`, clear both pointers, `fifo_numel`=0, `drop_cnt`=0 and `irq`=0; `evt_ready`=1 from the first cycle after reset.
- REQ-025 SHALL NOT reset storage contents.
- REQ-026 SHALL abandon any in-progress write or pop when reset occurs mid-operation, with no partial update.

Configuration
- REQ-027 SHALL gate IRQ logic with macro `EVENT_FIFO_IRQ_EN`.
- REQ-028 SHALL, when `EVENT_FIFO_IRQ_EN` is defined, implement `irq` as a hysteresis register: `irq` set when `fifo_numel` >= `irq_assert_thresh`, else cleared when `fifo_numel` <= `irq_deassert_thresh`, else held; updated one cycle after `fifo_numel`.
- REQ-029 SHALL give set priority over clear when both conditions hold.
- REQ-030 SHALL treat `irq_assert_thresh`=0 as disabled: `irq` never sets.
- REQ-031 SHALL, when `EVENT_FIFO_IRQ_EN` is undefined, tie `irq` to 0 and leave both threshold inputs unused.

Verification (FIFO_AWIDTH=4, CAP=15, RF_WIDTH=32)
- REQ-032 SHALL cover: reset, then write 15 events 0x100..0x10E -> `fifo_numel`=15, `evt_ready`=0; a 16th `evt_valid` cycle -> `drop_cnt`=1, contents unchanged.
- REQ-033 SHALL cover: 15 pops -> `fifo_rd_data` sequence 0x100..0x10E, `fifo_numel`=0; extra `fifo_rd_en` -> `fifo_numel` stays 0.
- REQ-034 SHALL cover: at `fifo_numel`=7, simultaneous write and pop for 20 cycles (pointer wrap) -> `fifo_numel` stays 7, data order preserved.
- REQ-035 SHALL cover, with IRQ_EN, assert=10, deassert=4: fill to 10 -> `irq`=1 a cycle later; pop to 5 -> `irq`=1; pop to 4 -> `irq`=0.
- REQ-036 SHALL cover: `fifo_rst_n`=0 for one cycle at `fifo_numel`=9, `drop_cnt`=3 -> both 0 next cycle, `irq`=0, next write read back correctly.
- REQ-037 SHALL cover: `rst` asserted during a concurrent write and pop -> all outputs at reset values next cycle.
